// File: rtl/bus_decoder3_if.sv
// simpleBUS bundle between one master, the decoder and three slaves.
// The slave modport is the decoder's view; master is the environment.
interface bus_decoder3_if;
  logic        m_req;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [2:0]  s_sel;
  logic        s_wr;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s0_rdata;
  logic [31:0] s1_rdata;
  logic [31:0] s2_rdata;
  logic [2:0]  s_ready;

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_addr,
    input  m_wdata,
    output m_ready,
    output m_err,
    output m_rdata,
    output s_sel,
    output s_wr,
    output s_addr,
    output s_wdata,
    input  s0_rdata,
    input  s1_rdata,
    input  s2_rdata,
    input  s_ready
  );

  modport master (
    output m_req,
    output m_wr,
    output m_addr,
    output m_wdata,
    input  m_ready,
    input  m_err,
    input  m_rdata,
    input  s_sel,
    input  s_wr,
    input  s_addr,
    input  s_wdata,
    output s0_rdata,
    output s1_rdata,
    output s2_rdata,
    output s_ready
  );
endinterface

// File: rtl/bus_decoder3.sv
// simpleBUS slave-side router: one master to three slaves with
// request latching, per-access timeout and error completion.
module bus_decoder3 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  bus_decoder3_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic [31:0] rsel;

  // Selected slave's ready and read data; other slaves are ignored.
  always_comb begin
    hit  = 1'b0;
    rsel = '0;
    unique case (1'b1)
      sel_q[0]: begin
        hit  = bus.s_ready[0];
        rsel = bus.s0_rdata;
      end
      sel_q[1]: begin
        hit  = bus.s_ready[1];
        rsel = bus.s1_rdata;
      end
      sel_q[2]: begin
        hit  = bus.s_ready[2];
        rsel = bus.s2_rdata;
      end
      default: begin
        hit  = 1'b0;
        rsel = '0;
      end
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          wr_d    = bus.m_wr;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          idx_d   = bus.m_addr[9:8];
          cnt_d   = '0;
          if (bus.m_addr[9:8] == 2'b11) begin
            state_d = ERR;
            sel_d   = 3'b000;
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            sel_d   = 3'b001 << bus.m_addr[9:8];
          end
        end
      end
      ACCESS: begin
        if (hit) begin
          state_d = RESP;
          sel_d   = 3'b000;
          rdy_d   = 1'b1;
          rdata_d = wr_q ? 32'h0 : rsel;
        end else if (cnt_q == LAST) begin
          state_d = ERR;
          sel_d   = 3'b000;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.m_ready = rdy_q;
  assign bus.m_err   = err_q;
  assign bus.m_rdata = rdata_q;
  assign bus.s_sel   = sel_q;
  assign bus.s_wr    = wr_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;

endmodule
